ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the rv32i pipeline. It is the consumer of the ID/EX pipeline register and the producer of the EX/MEM pipeline register.
- Performs operand forwarding, ALU operation, branch compare and branch-target computation.
- Registers results and control into EX/MEM, with hold on memory stall and bubble on an invalid input.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active low
mem_stall  in  1  MEM stage busy; freeze EX/MEM
ID_EX_PC  in  32  instruction PC
ID_EX_ReadData1  in  32  rs1 register value
ID_EX_ReadData2  in  32  rs2 register value
ID_EX_Immediate  in  32  sign-extended immediate
ID_EX_Rs1  in  5  source register 1
ID_EX_Rs2  in  5  source register 2
ID_EX_Rd  in  5  destination register
ID_EX_Funct7  in  7  funct7
ID_EX_Funct3  in  3  funct3
ID_EX_ALUOp  in  2  00 add, 01 branch compare, 10 funct-decoded
ID_EX_MemRead  in  1  load
ID_EX_MemtoReg  in  1  writeback from memory
ID_EX_MemWrite  in  1  store
ID_EX_ALUSrc  in  1  0: rs2 operand, 1: immediate
ID_EX_RegWrite  in  1  writes rd
ID_EX_enable_out  in  1  ID/EX entry valid
MEM_WB_Rd  in  5  writeback destination
MEM_WB_RegWrite  in  1  writeback valid write
MEM_WB_WriteData  in  32  writeback value
EX_MEM_PC  out  32  registered PC
EX_MEM_ALUResult  out  32  registered ALU result / address
EX_MEM_WriteData  out  32  registered forwarded rs2 (store data)
EX_MEM_Rd  out  5  registered rd
EX_MEM_Funct3  out  3  registered funct3 (access size)
EX_MEM_MemRead  out  1  registered
EX_MEM_MemtoReg  out  1  registered
EX_MEM_MemWrite  out  1  registered
EX_MEM_RegWrite  out  1  registered
EX_MEM_enable_out  out  1  EX/MEM entry valid
EX_branch_taken  out  1  combinational; branch resolved taken
EX_branch_target  out  32  combinational; ID_EX_PC + ID_EX_Immediate

Behaviour:

Reset (async, reset_n=0):
- All EX_MEM_* outputs are 0 immediately, independent of clk.
- Reset mid-stall also clears everything.

Forwarding (combinational), evaluated separately for opA (Rs1) and opB_reg (Rs2):
- Priority 1, from EX/MEM: taken if EX_MEM_enable_out & EX_MEM_RegWrite & !EX_MEM_MemRead & EX_MEM_Rd!=0 & EX_MEM_Rd==Rs. Source is EX_MEM_ALUResult.
- Priority 2, from MEM/WB: taken if MEM_WB_RegWrite & MEM_WB_Rd!=0 & MEM_WB_Rd==Rs. Source is MEM_WB_WriteData.
- Otherwise use ID_EX_ReadData.
- Load-use stalls are the hazard unit's job, not this block's.

Operands:
- opB = ALUSrc ? Immediate : opB_reg.
- Store data is always opB_reg.

ALU:
- ALUOp=00: opA+opB.
- ALUOp=01: opA-opB. Result is don't-care; it is written as the subtraction.
- ALUOp=10, decoded by Funct3:
  - 000: SUB when (!ALUSrc & Funct7[5]), else ADD.
  - 001: SLL, shift amount opB[4:0].
  - 010: SLT, signed.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA when Funct7[5], else SRL. Applies to both R-type and I-type.
  - 110: OR.
  - 111: AND.
- ALUOp=11: result 0.
- All arithmetic is modulo 2^32 with no overflow flag.

Branch:
- EX_branch_taken = ID_EX_enable_out & ALUOp==01 & condition(Funct3).
- Funct3 conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Funct3 010/011 give 0.
- Comparison uses the forwarded opA and opB_reg.
- EX_branch_target is always PC+Imm and is valid regardless of taken.
- EX_branch_taken is forced to 0 while mem_stall=1, so no flush fires on a frozen instruction.

EX/MEM register (posedge clk), priority order:
1. mem_stall=1: hold all EX_MEM_* unchanged.
2. ID_EX_enable_out=1: load all fields; EX_MEM_enable_out<=1.
3. Otherwise (bubble): EX_MEM_enable_out, MemRead, MemWrite, RegWrite, MemtoReg <=0. Data fields hold.

Latency: one cycle from ID/EX to EX/MEM.

Test Plan:
- ADD, no hazard: Rs1=x1=5, Rs2=x2=7, ALUOp=10, F3=000, ALUSrc=0, Rd=3, enable=1 -> next cycle EX_MEM_ALUResult=12, EX_MEM_RegWrite=1, EX_MEM_Rd=3, EX_MEM_enable_out=1.
- Forwarding priority: prior instr wrote x1=0x10 (in EX/MEM) and MEM_WB_Rd=1 with 0x20; SUB x1-x2 with x2=1 -> result 0x0F. MEM_WB_Rd=0 with RegWrite=1 -> no forward.
- Shift/compare: SRAI with opA=0x80000000, Imm=0x404 (Funct7[5]=1, shamt 4) -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0.
- Branch: BLT with opA=-1, opB=1, PC=0x100, Imm=0x20 -> EX_branch_taken=1, target 0x120. BLTU with the same operands -> 0. Same BLT with mem_stall=1 -> taken=0.
- Stall/bubble: load result, then mem_stall=1 for 3 cycles -> EX_MEM_* constant. Then enable=0 -> EX_MEM_enable_out=0, MemRead=0.
- Reset mid-operation: reset_n low between clock edges -> all EX_MEM_* read 0 before the next posedge.

Source files
------------

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
// The EX/MEM register holds on mem_stall. An invalid ID/EX entry inserts a bubble that clears only the control bits.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] ID_EX_PC,
    input  logic [XLEN-1:0] ID_EX_ReadData1,
    input  logic [XLEN-1:0] ID_EX_ReadData2,
    input  logic [XLEN-1:0] ID_EX_Immediate,
    input  logic [4:0]      ID_EX_Rs1,
    input  logic [4:0]      ID_EX_Rs2,
    input  logic [4:0]      ID_EX_Rd,
    input  logic [6:0]      ID_EX_Funct7,
    input  logic [2:0]      ID_EX_Funct3,
    input  logic [1:0]      ID_EX_ALUOp,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_MemtoReg,
    input  logic            ID_EX_MemWrite,
    input  logic            ID_EX_ALUSrc,
    input  logic            ID_EX_RegWrite,
    input  logic            ID_EX_enable_out,
    input  logic [4:0]      MEM_WB_Rd,
    input  logic            MEM_WB_RegWrite,
    input  logic [XLEN-1:0] MEM_WB_WriteData,
    output logic [XLEN-1:0] EX_MEM_PC,
    output logic [XLEN-1:0] EX_MEM_ALUResult,
    output logic [XLEN-1:0] EX_MEM_WriteData,
    output logic [4:0]      EX_MEM_Rd,
    output logic [2:0]      EX_MEM_Funct3,
    output logic            EX_MEM_MemRead,
    output logic            EX_MEM_MemtoReg,
    output logic            EX_MEM_MemWrite,
    output logic            EX_MEM_RegWrite,
    output logic            EX_MEM_enable_out,
    output logic            EX_branch_taken,
    output logic [XLEN-1:0] EX_branch_target
);

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_FUNCT  = 2'b10;

    logic [XLEN-1:0] pc_reg, alu_reg, wdata_reg;
    logic [4:0]      rd_reg;
    logic [2:0]      funct3_reg;
    logic            mem_read_reg, mem_to_reg_reg, mem_write_reg, reg_write_reg, valid_reg;

    // Loads in EX/MEM have no data yet, so they never forward.
    logic ex_fwd_ok;
    assign ex_fwd_ok = valid_reg & reg_write_reg & ~mem_read_reg & (rd_reg != 5'd0);

    logic [1:0][4:0]      rs_sel;
    logic [1:0][XLEN-1:0] rf_data;
    logic [1:0][XLEN-1:0] fwd_val;
    assign rs_sel  = {ID_EX_Rs2, ID_EX_Rs1};
    assign rf_data = {ID_EX_ReadData2, ID_EX_ReadData1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_ex, hit_wb;
            assign hit_ex = ex_fwd_ok & (rd_reg == rs_sel[gi]);
            assign hit_wb = MEM_WB_RegWrite & (MEM_WB_Rd != 5'd0) & (MEM_WB_Rd == rs_sel[gi]);
            assign fwd_val[gi] = hit_ex ? alu_reg :
                                 hit_wb ? MEM_WB_WriteData : rf_data[gi];
        end
    endgenerate

    logic [XLEN-1:0] op_a, op_b_reg, op_b;
    logic [4:0]      shamt;
    assign op_a     = fwd_val[0];
    assign op_b_reg = fwd_val[1];
    assign op_b     = ID_EX_ALUSrc ? ID_EX_Immediate : op_b_reg;
    assign shamt    = op_b[4:0];

    logic [XLEN-1:0] alu_next;
    always_comb begin
        alu_next = '0;
        case (ID_EX_ALUOp)
            OP_ADD:    alu_next = op_a + op_b;
            OP_BRANCH: alu_next = op_a - op_b;
            OP_FUNCT: begin
                case (ID_EX_Funct3)
                    3'b000: alu_next = (!ID_EX_ALUSrc && ID_EX_Funct7[5]) ? op_a - op_b : op_a + op_b;
                    3'b001: alu_next = op_a << shamt;
                    3'b010: alu_next = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_next = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b100: alu_next = op_a ^ op_b;
                    3'b101: alu_next = ID_EX_Funct7[5] ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
                    3'b110: alu_next = op_a | op_b;
                    default: alu_next = op_a & op_b;
                endcase
            end
            default: alu_next = '0;
        endcase
    end

    // Branch compare ignores ALUSrc: it always sees the forwarded rs2 value.
    logic cond;
    always_comb begin
        cond = 1'b0;
        case (ID_EX_Funct3)
            3'b000: cond = (op_a == op_b_reg);
            3'b001: cond = (op_a != op_b_reg);
            3'b100: cond = ($signed(op_a) < $signed(op_b_reg));
            3'b101: cond = ($signed(op_a) >= $signed(op_b_reg));
            3'b110: cond = (op_a < op_b_reg);
            3'b111: cond = (op_a >= op_b_reg);
            default: cond = 1'b0;
        endcase
    end

    assign EX_branch_taken  = ID_EX_enable_out & ~mem_stall & (ID_EX_ALUOp == OP_BRANCH) & cond;
    assign EX_branch_target = ID_EX_PC + ID_EX_Immediate;

    logic unused_funct7;
    assign unused_funct7 = ^{ID_EX_Funct7[6], ID_EX_Funct7[4:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg         <= '0;
            alu_reg        <= '0;
            wdata_reg      <= '0;
            rd_reg         <= '0;
            funct3_reg     <= '0;
            mem_read_reg   <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            reg_write_reg  <= 1'b0;
            valid_reg      <= 1'b0;
        end else if (mem_stall) begin
            // hold everything
        end else if (ID_EX_enable_out) begin
            pc_reg         <= ID_EX_PC;
            alu_reg        <= alu_next;
            wdata_reg      <= op_b_reg;
            rd_reg         <= ID_EX_Rd;
            funct3_reg     <= ID_EX_Funct3;
            mem_read_reg   <= ID_EX_MemRead;
            mem_to_reg_reg <= ID_EX_MemtoReg;
            mem_write_reg  <= ID_EX_MemWrite;
            reg_write_reg  <= ID_EX_RegWrite;
            valid_reg      <= 1'b1;
        end else begin
            mem_read_reg   <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            reg_write_reg  <= 1'b0;
            valid_reg      <= 1'b0;
        end
    end

    assign EX_MEM_PC         = pc_reg;
    assign EX_MEM_ALUResult  = alu_reg;
    assign EX_MEM_WriteData  = wdata_reg;
    assign EX_MEM_Rd         = rd_reg;
    assign EX_MEM_Funct3     = funct3_reg;
    assign EX_MEM_MemRead    = mem_read_reg;
    assign EX_MEM_MemtoReg   = mem_to_reg_reg;
    assign EX_MEM_MemWrite   = mem_write_reg;
    assign EX_MEM_RegWrite   = reg_write_reg;
    assign EX_MEM_enable_out = valid_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: hand-computed vectors, one task per scenario.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_stall = 1'b0;
    logic [31:0] ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Immediate;
    logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
    logic [6:0]  ID_EX_Funct7;
    logic [2:0]  ID_EX_Funct3;
    logic [1:0]  ID_EX_ALUOp;
    logic        ID_EX_MemRead, ID_EX_MemtoReg, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_RegWrite, ID_EX_enable_out;
    logic [4:0]  MEM_WB_Rd;
    logic        MEM_WB_RegWrite;
    logic [31:0] MEM_WB_WriteData;
    logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData, EX_branch_target;
    logic [4:0]  EX_MEM_Rd;
    logic [2:0]  EX_MEM_Funct3;
    logic        EX_MEM_MemRead, EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_enable_out;
    logic        EX_branch_taken;

    int n_checks = 0;
    int n_fail = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .mem_stall(mem_stall),
        .ID_EX_PC(ID_EX_PC), .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_Immediate(ID_EX_Immediate), .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_Funct7(ID_EX_Funct7), .ID_EX_Funct3(ID_EX_Funct3), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_enable_out(ID_EX_enable_out),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_WriteData(MEM_WB_WriteData),
        .EX_MEM_PC(EX_MEM_PC), .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_Funct3(EX_MEM_Funct3), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_enable_out(EX_MEM_enable_out), .EX_branch_taken(EX_branch_taken), .EX_branch_target(EX_branch_target)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [1:0] aluop, input logic alusrc, input logic memread,
                         input logic regwrite);
        ID_EX_PC = pc; ID_EX_Rs1 = rs1; ID_EX_ReadData1 = v1; ID_EX_Rs2 = rs2; ID_EX_ReadData2 = v2;
        ID_EX_Immediate = imm; ID_EX_Rd = rd; ID_EX_Funct7 = f7; ID_EX_Funct3 = f3; ID_EX_ALUOp = aluop;
        ID_EX_ALUSrc = alusrc; ID_EX_MemRead = memread; ID_EX_MemtoReg = memread; ID_EX_MemWrite = 1'b0;
        ID_EX_RegWrite = regwrite; ID_EX_enable_out = 1'b1;
        $display("txn pc=%h rs1=%0d rs2=%0d rd=%0d aluop=%b f3=%b", pc, rs1, rs2, rd, aluop, f3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 7'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        ID_EX_enable_out = 1'b0;
        MEM_WB_Rd = 5'd0; MEM_WB_RegWrite = 1'b0; MEM_WB_WriteData = 32'h0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_Rd, EX_MEM_Funct3, EX_MEM_MemRead,
             EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_enable_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h alu=%h en=%b required all zero", EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_enable_out);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_add();
        drive(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 7'h00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'd12 || EX_MEM_RegWrite !== 1'b1 || EX_MEM_Rd !== 5'd3 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++;
            $display("FAIL add: got alu=%h rw=%b rd=%0d en=%b required 0000000c 1 3 1",
                     EX_MEM_ALUResult, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_enable_out);
        end
        n_checks++;
        if (EX_MEM_PC !== 32'h40 || EX_MEM_WriteData !== 32'd7) begin
            n_fail++;
            $display("FAIL add_fields: got pc=%h wdata=%h required 00000040 00000007", EX_MEM_PC, EX_MEM_WriteData);
        end
    endtask

    task automatic test_forwarding();
        // x1 = 0x10 lands in EX/MEM
        drive(32'h44, 5'd0, 32'h0, 5'd0, 32'h0, 32'h10, 5'd1, 7'h00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        // SUB x4 = x1 - x2; EX/MEM (0x10) beats MEM/WB (0x20)
        drive(32'h48, 5'd1, 32'hDEAD, 5'd2, 32'd1, 32'h0, 5'd4, 7'h20, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        MEM_WB_Rd = 5'd1; MEM_WB_RegWrite = 1'b1; MEM_WB_WriteData = 32'h20;
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h0F) begin
            n_fail++;
            $display("FAIL fwd_priority: got %h required 0000000f", EX_MEM_ALUResult);
        end
        // EX/MEM now holds x4, so only MEM/WB matches x1
        drive(32'h4C, 5'd1, 32'h100, 5'd2, 32'd1, 32'h0, 5'd5, 7'h00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h21) begin
            n_fail++;
            $display("FAIL fwd_memwb: got %h required 00000021", EX_MEM_ALUResult);
        end
        // MEM/WB writing x0 must not forward
        drive(32'h50, 5'd0, 32'd7, 5'd2, 32'd3, 32'h0, 5'd6, 7'h00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        MEM_WB_Rd = 5'd0; MEM_WB_WriteData = 32'h55;
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'd10) begin
            n_fail++;
            $display("FAIL fwd_x0: got %h required 0000000a", EX_MEM_ALUResult);
        end
        MEM_WB_RegWrite = 1'b0;
        // Load in EX/MEM must not forward its address
        drive(32'h54, 5'd0, 32'h0, 5'd0, 32'h0, 32'h40, 5'd7, 7'h00, 3'b010, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        drive(32'h58, 5'd7, 32'h3, 5'd0, 32'h0, 32'h0, 5'd9, 7'h00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h3) begin
            n_fail++;
            $display("FAIL fwd_load: got %h required 00000003", EX_MEM_ALUResult);
        end
    endtask

    task automatic test_shift_compare();
        drive(32'h60, 5'd10, 32'h80000000, 5'd0, 32'h0, 32'h404, 5'd8, 7'h20, 3'b101, 2'b10, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'hF8000000) begin
            n_fail++;
            $display("FAIL srai: got %h required f8000000", EX_MEM_ALUResult);
        end
        drive(32'h64, 5'd10, 32'h80000000, 5'd0, 32'h0, 32'h004, 5'd8, 7'h00, 3'b101, 2'b10, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h08000000) begin
            n_fail++;
            $display("FAIL srli: got %h required 08000000", EX_MEM_ALUResult);
        end
        drive(32'h68, 5'd10, 32'd1, 5'd11, 32'hFFFFFFFF, 32'h0, 5'd12, 7'h00, 3'b011, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'd1) begin
            n_fail++;
            $display("FAIL sltu: got %h required 00000001", EX_MEM_ALUResult);
        end
        drive(32'h6C, 5'd10, 32'd1, 5'd11, 32'hFFFFFFFF, 32'h0, 5'd13, 7'h00, 3'b010, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'd0) begin
            n_fail++;
            $display("FAIL slt: got %h required 00000000", EX_MEM_ALUResult);
        end
        // shift amount uses only opB[4:0]: 0x25 -> 5
        drive(32'h70, 5'd10, 32'd3, 5'd11, 32'h25, 32'h0, 5'd14, 7'h00, 3'b001, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h60) begin
            n_fail++;
            $display("FAIL sll: got %h required 00000060", EX_MEM_ALUResult);
        end
    endtask

    task automatic test_branch();
        drive(32'h100, 5'd20, 32'hFFFFFFFF, 5'd21, 32'd1, 32'h20, 5'd0, 7'h00, 3'b100, 2'b01, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (EX_branch_taken !== 1'b1 || EX_branch_target !== 32'h120) begin
            n_fail++;
            $display("FAIL blt: got taken=%b target=%h required 1 00000120", EX_branch_taken, EX_branch_target);
        end
        ID_EX_Funct3 = 3'b110;
        #1;
        n_checks++;
        if (EX_branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL bltu: got taken=%b required 0", EX_branch_taken);
        end
        ID_EX_Funct3 = 3'b100;
        mem_stall = 1'b1;
        #1;
        n_checks++;
        if (EX_branch_taken !== 1'b0 || EX_branch_target !== 32'h120) begin
            n_fail++;
            $display("FAIL blt_stall: got taken=%b target=%h required 0 00000120", EX_branch_taken, EX_branch_target);
        end
        mem_stall = 1'b0;
        ID_EX_Funct3 = 3'b101;
        #1;
        n_checks++;
        if (EX_branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL bge: got taken=%b required 0", EX_branch_taken);
        end
        tick();
    endtask

    task automatic test_stall_bubble();
        drive(32'h200, 5'd22, 32'h1000, 5'd23, 32'hCAFE, 32'h8, 5'd17, 7'h00, 3'b010, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h1008 || EX_MEM_MemRead !== 1'b1 || EX_MEM_MemtoReg !== 1'b1 || EX_MEM_Funct3 !== 3'b010) begin
            n_fail++;
            $display("FAIL load: got alu=%h mr=%b m2r=%b f3=%b required 00001008 1 1 010",
                     EX_MEM_ALUResult, EX_MEM_MemRead, EX_MEM_MemtoReg, EX_MEM_Funct3);
        end
        mem_stall = 1'b1;
        drive(32'h300, 5'd1, 32'h5, 5'd2, 32'h6, 32'h0, 5'd18, 7'h00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (EX_MEM_ALUResult !== 32'h1008 || EX_MEM_PC !== 32'h200 || EX_MEM_Rd !== 5'd17 ||
                EX_MEM_MemRead !== 1'b1 || EX_MEM_enable_out !== 1'b1 || EX_MEM_WriteData !== 32'hCAFE) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got alu=%h pc=%h rd=%0d mr=%b required 00001008 00000200 17 1",
                         i, EX_MEM_ALUResult, EX_MEM_PC, EX_MEM_Rd, EX_MEM_MemRead);
            end
        end
        mem_stall = 1'b0;
        ID_EX_enable_out = 1'b0;
        tick();
        n_checks++;
        if (EX_MEM_enable_out !== 1'b0 || EX_MEM_MemRead !== 1'b0 || EX_MEM_RegWrite !== 1'b0 || EX_MEM_MemtoReg !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_ctrl: got en=%b mr=%b rw=%b m2r=%b required 0 0 0 0",
                     EX_MEM_enable_out, EX_MEM_MemRead, EX_MEM_RegWrite, EX_MEM_MemtoReg);
        end
        n_checks++;
        if (EX_MEM_ALUResult !== 32'h1008 || EX_MEM_Rd !== 5'd17) begin
            n_fail++;
            $display("FAIL bubble_data: got alu=%h rd=%0d required 00001008 17", EX_MEM_ALUResult, EX_MEM_Rd);
        end
    endtask

    task automatic test_reset_mid();
        drive(32'h400, 5'd24, 32'h11, 5'd25, 32'h22, 32'h0, 5'd26, 7'h00, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1);
        tick();
        mem_stall = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_Rd, EX_MEM_Funct3, EX_MEM_MemRead,
             EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_enable_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got pc=%h alu=%h rd=%0d en=%b required all zero",
                     EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_Rd, EX_MEM_enable_out);
        end
        #1 reset_n = 1'b1;
        mem_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_shift_compare();
        test_branch();
        test_stall_bubble();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
